// File: rtl/round_sequencer_pkg.sv
// Shared encodings for the round sequencer: verdict/result codes and FSM states.
package round_sequencer_pkg;

    typedef enum logic [1:0] {
        WL_NONE  = 2'b00,
        WL_MINE  = 2'b01,
        WL_ENEMY = 2'b10,
        WL_DRAW  = 2'b11
    } wl_t;

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_Q, ANSWER, RESOLVE, GAP, OVER
    } state_t;

    localparam logic [7:0] ROUND_SAT = 8'd255;

    // A zero-HP finish and a round-cap finish both reduce to "who is ahead".
    function automatic wl_t rank_hp(input logic my_ahead, input logic en_ahead);
        if (my_ahead) return WL_MINE;
        if (en_ahead) return WL_ENEMY;
        return WL_DRAW;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter shared by the answer window and the post-resolve gap.
module round_timer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt_nxt = cnt;
        if (load)
            cnt_nxt = load_val;
        else if (cnt != '0)
            cnt_nxt = cnt - CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cnt <= '0;
        else      cnt <= cnt_nxt;
    end

    // High on the final cycle of a window.
    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/round_sequencer.sv
// Round controller: question request, timed answer window, damage, game over.
// Optional round cap enabled by defining ROUND_LIMIT_EN (adds MAX_ROUNDS).
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int HP_INIT    = 5,
    parameter int HP_W       = 4,
    parameter int DAMAGE     = 1,
    parameter int TIME_LIMIT = 1000,
    parameter int GAP_CYC    = 50,
    parameter int CNT_W      = 16
`ifdef ROUND_LIMIT_EN
    , parameter int MAX_ROUNDS = 10
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             Q_ACK,
    input  logic [1:0]       WL_IN,
    output logic             Q_REQ,
    output logic             ANS_EN,
    output logic [HP_W-1:0]  MY_HP,
    output logic [HP_W-1:0]  EN_HP,
    output logic [7:0]       ROUND_NO,
    output logic [CNT_W-1:0] TIMER,
    output logic             GAME_OVER,
    output logic [1:0]       RESULT
);

    localparam logic [HP_W-1:0] HP0 = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0] DMG = HP_W'(DAMAGE);

    state_t           state, state_n;
    wl_t              wl, verdict, result;
    logic             timeout, round_cap, hp_dead, game_start;
    logic             tmr_load, tmr_last;
    logic [CNT_W-1:0] tmr_val, tmr_nxt, timer_q;
    logic [HP_W-1:0]  my_hp, en_hp;
    logic [7:0]       round_no;
    logic             q_req, ans_en, game_over;

    function automatic logic [HP_W-1:0] hp_sub(input logic [HP_W-1:0] hp);
        return (hp > DMG) ? hp - DMG : '0;
    endfunction

    assign wl         = wl_t'(WL_IN);
    assign hp_dead    = (my_hp == '0) || (en_hp == '0);
    assign game_start = START && (state == IDLE || state == OVER);

`ifdef ROUND_LIMIT_EN
    assign round_cap = (round_no == 8'(MAX_ROUNDS));
`else
    assign round_cap = 1'b0;
`endif

    round_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt_nxt  (tmr_nxt),
        .last     (tmr_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = CNT_W'(TIME_LIMIT);
        case (state)
            IDLE, OVER: if (START) state_n = REQ;
            REQ:        state_n = Q_ACK ? ANSWER : WAIT_Q;
            WAIT_Q:     if (Q_ACK) state_n = ANSWER;
            ANSWER:     if (wl != WL_NONE || tmr_last) state_n = RESOLVE;
            RESOLVE:    state_n = GAP;
            GAP:        if (tmr_last) state_n = (hp_dead || round_cap) ? OVER : REQ;
            default:    state_n = IDLE;
        endcase
        // Timer is (re)loaded on entry to either timed window.
        if (state_n == ANSWER && state != ANSWER) begin
            tmr_load = 1'b1;
        end else if (state_n == GAP && state != GAP) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(GAP_CYC);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            my_hp     <= HP0;
            en_hp     <= HP0;
            round_no  <= '0;
            verdict   <= WL_NONE;
            timeout   <= 1'b0;
            result    <= WL_NONE;
            q_req     <= 1'b0;
            ans_en    <= 1'b0;
            game_over <= 1'b0;
            timer_q   <= '0;
        end else begin
            q_req     <= (state_n == REQ);
            ans_en    <= (state_n == ANSWER);
            game_over <= (state_n == OVER);
            timer_q   <= (state_n == ANSWER) ? tmr_nxt : '0;
            if (game_start) begin
                my_hp    <= HP0;
                en_hp    <= HP0;
                round_no <= 8'd1;
                result   <= WL_NONE;
            end
            // Latched every answer cycle; only the exit cycle's value survives.
            if (state == ANSWER) begin
                verdict <= wl;
                timeout <= (wl == WL_NONE);
            end
            if (state == RESOLVE) begin
                if (timeout || verdict == WL_MINE)  en_hp <= hp_sub(en_hp);
                if (timeout || verdict == WL_ENEMY) my_hp <= hp_sub(my_hp);
            end
            if (state == GAP && tmr_last) begin
                if (state_n == OVER)
                    result <= rank_hp(my_hp > en_hp, en_hp > my_hp);
                else if (round_no != ROUND_SAT)
                    round_no <= round_no + 8'd1;
            end
        end
    end

    assign Q_REQ     = q_req;
    assign ANS_EN    = ans_en;
    assign MY_HP     = my_hp;
    assign EN_HP     = en_hp;
    assign ROUND_NO  = round_no;
    assign TIMER     = timer_q;
    assign GAME_OVER = game_over;
    assign RESULT    = result;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: each round's timeline is computed from the chosen
// ack delay, verdict and verdict cycle, and every output is checked each cycle.
module tb_round_sequencer;

    localparam int HP_INIT = 5;
    localparam int HP_W    = 4;
    localparam int DMG     = 1;
    localparam int TL      = 1000;
    localparam int GAPC    = 50;
    localparam int CNT_W   = 16;
`ifdef ROUND_LIMIT_EN
    localparam int MAXR    = 2;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             START = 1'b0;
    logic             Q_ACK = 1'b0;
    logic [1:0]       WL_IN = 2'b00;
    logic             Q_REQ, ANS_EN, GAME_OVER;
    logic [HP_W-1:0]  MY_HP, EN_HP;
    logic [7:0]       ROUND_NO;
    logic [CNT_W-1:0] TIMER;
    logic [1:0]       RESULT;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: game-level quantities only.
    int m_my, m_en, m_round, m_res;
    bit m_over;

    always #5 CLK = ~CLK;

    round_sequencer #(
        .HP_INIT(HP_INIT), .HP_W(HP_W), .DAMAGE(DMG), .TIME_LIMIT(TL),
        .GAP_CYC(GAPC), .CNT_W(CNT_W)
`ifdef ROUND_LIMIT_EN
        , .MAX_ROUNDS(MAXR)
`endif
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .Q_ACK(Q_ACK), .WL_IN(WL_IN),
        .Q_REQ(Q_REQ), .ANS_EN(ANS_EN), .MY_HP(MY_HP), .EN_HP(EN_HP),
        .ROUND_NO(ROUND_NO), .TIMER(TIMER), .GAME_OVER(GAME_OVER), .RESULT(RESULT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outs(input bit eq, input bit ea, input int et);
        chk("q_req",     Q_REQ,     eq);
        chk("ans_en",    ANS_EN,    ea);
        chk("timer",     TIMER,     et);
        chk("my_hp",     MY_HP,     m_my);
        chk("en_hp",     EN_HP,     m_en);
        chk("round_no",  ROUND_NO,  m_round);
        chk("game_over", GAME_OVER, m_over);
        chk("result",    RESULT,    m_res);
    endtask

    function automatic bit rb(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic logic [1:0] rwl();
        return 2'($urandom_range(0, 3));
    endfunction

    // Check this cycle's outputs, then drive the inputs sampled at its end.
    task automatic cyc(input bit st, input bit qa, input logic [1:0] wl,
                       input bit eq, input bit ea, input int et);
        @(negedge CLK);
        chk_outs(eq, ea, et);
        START = st;
        Q_ACK = qa;
        WL_IN = wl;
    endtask

    task automatic model_reset();
        m_my = HP_INIT; m_en = HP_INIT; m_round = 0; m_res = 0; m_over = 0;
    endtask

    task automatic finish_game();
        m_over = 1;
        if (m_en == 0 && m_my > 0)      m_res = 1;
        else if (m_my == 0 && m_en > 0) m_res = 2;
        else if (m_my == 0 && m_en == 0) m_res = 3;
        else m_res = (m_my > m_en) ? 1 : (m_en > m_my) ? 2 : 3;
    endtask

    task automatic new_game();
        cyc(1'b1, rb(50), rwl(), 1'b0, 1'b0, 0);
        m_my = HP_INIT; m_en = HP_INIT; m_round = 1; m_res = 0; m_over = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rb(50), rwl(), 1'b0, 1'b0, 0);
    endtask

    // d: wait-for-ack cycles after REQ; v: verdict (0 = timeout); k: verdict cycle (1-based).
    task automatic play_round(input int d, input int v, input int k, input bit hold);
        int len;
        logic [1:0] after;
        if (m_over) return;
        len = (v == 0) ? TL : k;
        cyc(rb(10), d == 0, rwl(), 1'b1, 1'b0, 0);
        for (int i = 1; i <= d; i++) cyc(rb(10), i == d, rwl(), 1'b0, 1'b0, 0);
        for (int i = 0; i < len; i++)
            cyc(rb(10), rb(50), (i == len - 1) ? 2'(v) : 2'b00, 1'b0, 1'b1, TL - i);
        after = hold ? 2'(v) : rwl();
        cyc(rb(10), rb(50), after, 1'b0, 1'b0, 0);
        if (v == 0 || v == 1) m_en = (m_en > DMG) ? m_en - DMG : 0;
        if (v == 0 || v == 2) m_my = (m_my > DMG) ? m_my - DMG : 0;
        for (int i = 0; i < GAPC; i++)
            cyc(rb(10), rb(50), hold ? 2'(v) : rwl(), 1'b0, 1'b0, 0);
        if (m_my == 0 || m_en == 0) finish_game();
`ifdef ROUND_LIMIT_EN
        else if (m_round == MAXR) finish_game();
`endif
        else if (m_round < 255) m_round++;
    endtask

    initial begin
        model_reset();
        cyc(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 0);
        RST = 1'b1;
        idle_cycles(3);

        // Win, timeout, late enemy verdict, then enemy wins until own HP runs out.
        new_game();
        play_round(0, 1, 1, 1'b0);
        play_round(0, 0, 0, 1'b0);
        play_round(2, 2, TL, 1'b0);
        for (int r = 0; r < 8 && !m_over; r++)
            play_round($urandom_range(0, 3), 2, $urandom_range(1, 20), 1'b0);
        idle_cycles(5);

        // Five timeouts: both players reach zero together.
        new_game();
        for (int r = 0; r < 5; r++) play_round(0, 0, 0, 1'b0);
        idle_cycles(3);

        // Verdict held through resolve and gap must count once.
        new_game();
        play_round(1, 1, 5, 1'b1);
        play_round(0, 2, 3, 1'b1);
        for (int r = 0; r < 12 && !m_over; r++)
            play_round(0, 1, $urandom_range(1, 10), 1'b0);
        idle_cycles(3);

`ifdef ROUND_LIMIT_EN
        new_game();
        for (int r = 0; r < 4 && !m_over; r++) play_round(0, 3, 2, 1'b0);
        idle_cycles(3);
`endif

        for (int g = 0; g < 4; g++) begin
            new_game();
            for (int r = 0; r < 40 && !m_over; r++) begin
                int v, pick;
                pick = $urandom_range(0, 99);
                v = (pick < 8) ? 0 : (pick < 44) ? 1 : (pick < 80) ? 2 : 3;
                if (r >= 20) v = 2;
                play_round($urandom_range(0, 3), v,
                           (pick % 7 == 0) ? TL : $urandom_range(1, 40),
                           (v != 0) && rb(25));
            end
            idle_cycles(4);
        end

        // Asynchronous reset in the answer window with a verdict pending.
        new_game();
        cyc(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, TL);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, TL - 1);
        cyc(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, TL - 2);
        #2 RST = 1'b0;
        model_reset();
        #1 chk_outs(1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 0);
        RST = 1'b1;
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Game-round controller for the factorization battle. It requests a question from the problem generator and opens the answer window with a timeout. It consumes the 2-bit win/lose verdict, applies damage to both players' HP, and declares game over. It sits between the win/lose judge and the HP display / question logic, and owns all round sequencing.

Parameters:
HP_INIT, 5, starting HP for both players.
HP_W, 4, HP register width; HP_INIT must be below 2**HP_W.
DAMAGE, 1, HP removed from the loser per round.
TIME_LIMIT, 1000, answer-window length in CLK cycles; must be ≥ 1.
GAP_CYC, 50, cycles of pause after each resolve.
CNT_W, 16, timer width; must hold TIME_LIMIT and GAP_CYC.
MAX_ROUNDS, 10, round cap; used only with ROUND_LIMIT_EN.

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
START  in  1  one-cycle pulse: begin a new game
Q_ACK  in  1  question generator has a new question ready
WL_IN  in  2  verdict: 00 none, 01 own win, 10 enemy win, 11 draw
Q_REQ  out  1  one-cycle pulse requesting a new question
ANS_EN  out  1  high while answers are accepted
MY_HP  out  HP_W  own HP
EN_HP  out  HP_W  enemy HP
ROUND_NO  out  8  current round, starts at 1, saturates at 255
TIMER  out  CNT_W  remaining answer cycles; 0 outside ANSWER
GAME_OVER  out  1  high while in OVER
RESULT  out  2  00 undecided, 01 own win, 10 enemy win, 11 draw

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; MY_HP=EN_HP=HP_INIT; ROUND_NO=0; TIMER=0; Q_REQ=ANS_EN=GAME_OVER=0; RESULT=00. All outputs are registered.
- States and transitions:
  - IDLE: on START, load both HPs with HP_INIT, set ROUND_NO=1 and RESULT=00, then go to REQ.
  - REQ: Q_REQ=1 for exactly one cycle. Go to ANSWER if Q_ACK is high in the same cycle, otherwise go to WAIT_Q.
  - WAIT_Q: hold until Q_ACK, then go to ANSWER. There is no timeout here.
  - ANSWER: ANS_EN=1. TIMER loads TIME_LIMIT on entry and decrements each cycle.
    - If WL_IN≠00, latch the verdict and go to RESOLVE.
    - Otherwise, when TIMER=1, latch the verdict as "timeout" and go to RESOLVE.
    - If WL_IN≠00 in the same cycle as TIMER=1, the verdict wins over the timeout.
  - RESOLVE (one cycle), ANS_EN=0, damage applied:
    - 01: EN_HP -= DAMAGE.
    - 10: MY_HP -= DAMAGE.
    - 11: no change.
    - timeout: both lose DAMAGE.
    - Subtraction saturates at 0. New HP values are visible on the next cycle.
  - GAP: TIMER counts GAP_CYC cycles. Then:
    - If either HP is 0, go to OVER.
    - Otherwise increment ROUND_NO and go to REQ.
  - OVER: GAME_OVER=1. RESULT is 01 if EN_HP=0 and MY_HP>0, 10 for the reverse, 11 if both are 0. START restarts the game exactly as from IDLE.
- WL_IN is ignored outside ANSWER, so a stale verdict after RESOLVE cannot double-count.
- START is ignored outside IDLE and OVER.
- Q_ACK is ignored outside REQ and WAIT_Q.
- Reset mid-round aborts immediately to the reset values; no partial damage is applied.

Optional Feature:
ROUND_LIMIT_EN.
- Defined: at the end of GAP, if ROUND_NO=MAX_ROUNDS and both HP are nonzero, go to OVER. RESULT is decided by the higher HP; equal HP gives 11.
- Undefined: there is no round cap. The game ends only on HP=0 and MAX_ROUNDS is unused.

Decomposition:
- Shared package holds:
  - WL encodings (WL_NONE=00, WL_MINE=01, WL_ENEMY=10, WL_DRAW=11), reused by RESULT.
  - The state enum: IDLE, REQ, WAIT_Q, ANSWER, RESOLVE, GAP, OVER.
- One natural sub-module, round_timer: loadable down-counter with an expiry flag, used for both the ANSWER and GAP windows.

Test Plan:
- Reset then START with Q_ACK tied high → Q_REQ pulses 1 cycle; ANS_EN rises 1 cycle later; TIMER=1000 on the first ANSWER cycle.
- In ANSWER drive WL_IN=01 for 1 cycle → EN_HP 5→4 two cycles later; MY_HP stays 5; ROUND_NO becomes 2 after 50 GAP cycles.
- Hold WL_IN=00 for the whole window → timeout after 1000 cycles; both HP drop 5→4. Repeat with WL_IN=10 on the TIMER=1 cycle → only MY_HP drops.
- Drive five consecutive WL_IN=10 rounds → MY_HP=0, GAME_OVER=1, RESULT=10. Later WL_IN pulses cause no change; START resets both HP to 5.
- Both HP=1 then timeout → both 0, RESULT=11. Hold WL_IN=01 through RESOLVE and GAP → single decrement only.
- Assert RST low during ANSWER → all outputs at reset values asynchronously. With ROUND_LIMIT_EN and MAX_ROUNDS=2, two draw rounds → OVER with RESULT=11.
